knockout_controller: RTL

- Downstream consumer of the pipelined instruction-match trigger (`trig1`).
- Counts qualified trigger events and waits a programmable delay.
- Then asserts a registered `knockout` window of programmable length, which the SQED demo harness uses to suppress/corrupt instruction issue.
- Supports one-shot and auto-rearm operation, plus a status/observation interface.

---
 rtl/knockout_controller.sv | 85 ++++++++
 1 files changed

// File: rtl/knockout_controller.sv
// knockout_controller: counts qualified trigger edges, waits a delay, then drives a registered knockout window
module knockout_controller #(
  parameter int CNT_W = 8,
  parameter int DLY_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             disarm,
  input  logic             auto_rearm,
  input  logic [CNT_W-1:0] hit_target,
  input  logic [DLY_W-1:0] delay_cycles,
  input  logic [LEN_W-1:0] ko_len,
  input  logic             trig1,
  input  logic             trig_valid,
  output logic             knockout,
  output logic             ko_start,
  output logic             armed,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, KNOCK, DONE} state_t;
  state_t state, nxt;
  logic q, q_d, hit, last, latch;
  logic [CNT_W-1:0] tgt_s;
  logic [DLY_W-1:0] dly_s, dly_c;
  logic [LEN_W-1:0] len_s, len_c, len_eff;
  logic [CNT_W:0] tgt_eff;
  logic ar_s;
  assign q = trig1 & trig_valid;
  assign hit = q & ~q_d;
  assign tgt_eff = tgt_s == '0 ? (CNT_W+1)'(1) : {1'b0, tgt_s};
  assign len_eff = len_s == '0 ? LEN_W'(1) : len_s;
  assign last = ({1'b0, hit_count} + (CNT_W+1)'(1)) >= tgt_eff;
  assign latch = nxt == ARMED && (state == IDLE || state == DONE);
  always_comb begin
    nxt = state;
    if (disarm) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = arm ? ARMED : IDLE;
        ARMED:   nxt = hit && last ? (dly_s == '0 ? KNOCK : DELAY) : ARMED;
        DELAY:   nxt = dly_c == DLY_W'(1) ? KNOCK : DELAY;
        KNOCK:   nxt = len_c == LEN_W'(1) ? (ar_s ? ARMED : DONE) : KNOCK;
        DONE:    nxt = arm ? ARMED : DONE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_d <= 1'b0;
      knockout <= 1'b0;
      ko_start <= 1'b0;
      armed <= 1'b0;
      done <= 1'b0;
      hit_count <= '0;
      tgt_s <= '0;
      dly_s <= '0;
      len_s <= '0;
      ar_s <= 1'b0;
      dly_c <= '0;
      len_c <= '0;
    end else begin
      q_d <= q;
      state <= nxt;
      knockout <= nxt == KNOCK;
      ko_start <= nxt == KNOCK && state != KNOCK;
      armed <= nxt == ARMED;
      done <= nxt == DONE;
      dly_c <= state == DELAY ? dly_c - DLY_W'(1) : dly_s;
      len_c <= state == KNOCK ? len_c - LEN_W'(1) : len_eff;
      if (latch) begin
        tgt_s <= hit_target;
        dly_s <= delay_cycles;
        len_s <= ko_len;
        ar_s <= auto_rearm;
        hit_count <= '0;
      end
      if (state == KNOCK && nxt == ARMED) hit_count <= '0;
      if (state == ARMED && hit && !disarm) hit_count <= &hit_count ? hit_count : hit_count + CNT_W'(1);
    end
  end
endmodule
